// File: rtl/locked_axis_sequencer.sv
// Key-locked multi-axis pick-and-return sequencer.
// Axes are driven one at a time, the part is gripped, then the return path
// goes through a key-gated branch. A wrong key selects a decoy return state
// that behaves normally for CORRUPT_AFTER-1 entries and then stops counting
// and pulsing. All state updates on the falling clock edge.
// The spec's `release` output is named release_out here, because `release`
// is a reserved SystemVerilog keyword. dbg_state exposes the FSM state.
module locked_axis_sequencer #(
  parameter int               N_AXIS        = 3,
  parameter int               KEY_W         = 4,
  parameter logic [KEY_W-1:0] KEY_VAL       = 4'hA,
  parameter int               CORRUPT_AFTER = 5,
  parameter int               TIMEOUT       = 16,
  parameter int               CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N_AXIS-1:0] sense,
  input  logic              grip_ok,
  input  logic [KEY_W-1:0]  keyinput,
  output logic [N_AXIS-1:0] motor_en,
  output logic              grip,
  output logic              release_out,
  output logic              done,
  output logic              busy,
  output logic              fault,
  output logic [CNT_W-1:0]  job_cnt,
  output logic [2:0]        dbg_state
);

  localparam int AX_W = (N_AXIS > 1) ? $clog2(N_AXIS) : 1;
  localparam int WD_W = $clog2(TIMEOUT);
  localparam int TR_W = $clog2(CORRUPT_AFTER + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MOVE  = 3'd1,
    S_GRIP  = 3'd2,
    S_CHECK = 3'd3,
    S_RET   = 3'd4,
    S_RET_D = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t           r_state;
  logic [AX_W-1:0]  r_ax;
  logic [WD_W-1:0]  r_wd;
  logic [TR_W-1:0]  r_trip;
  logic [CNT_W-1:0] r_job_cnt;

  state_t           w_state_nxt;
  logic [AX_W-1:0]  w_ax_nxt;
  logic [WD_W-1:0]  w_wd_nxt;
  logic [TR_W-1:0]  w_trip_nxt;
  logic [CNT_W-1:0] w_job_nxt;

  logic w_sense_cur;
  logic w_last_ax;
  logic w_wd_expired;
  logic w_decoy_live;

  assign w_sense_cur  = sense[r_ax];
  assign w_last_ax    = (r_ax == AX_W'(N_AXIS - 1));
  assign w_wd_expired = (r_wd == WD_W'(TIMEOUT - 1));
  // The decoy stays convincing until trip_cnt has reached CORRUPT_AFTER.
  assign w_decoy_live = (r_trip < TR_W'(CORRUPT_AFTER));

  // State, axis index, watchdog, trip and job counters.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_ax      <= '0;
      r_wd      <= '0;
      r_trip    <= '0;
      r_job_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ax      <= w_ax_nxt;
      r_wd      <= w_wd_nxt;
      r_trip    <= w_trip_nxt;
      r_job_cnt <= w_job_nxt;
    end
  end

  // Next-state logic. The watchdog defaults to clear, so any state or axis
  // change restarts it; it only counts while waiting in MOVE or GRIP.
  // Abort overrides every transition, including its counter side effects.
  always_comb begin
    w_state_nxt = r_state;
    w_ax_nxt    = r_ax;
    w_wd_nxt    = '0;
    w_trip_nxt  = r_trip;
    w_job_nxt   = r_job_cnt;
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_MOVE;
            w_ax_nxt    = '0;
          end
        end
        S_MOVE: begin
          if (w_sense_cur) begin
            if (w_last_ax) w_state_nxt = S_GRIP;
            else           w_ax_nxt    = r_ax + 1'b1;
          end else if (w_wd_expired) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_wd_nxt = r_wd + 1'b1;
          end
        end
        S_GRIP: begin
          if (grip_ok)           w_state_nxt = S_CHECK;
          else if (w_wd_expired) w_state_nxt = S_FAULT;
          else                   w_wd_nxt    = r_wd + 1'b1;
        end
        S_CHECK: begin
          if (keyinput == KEY_VAL) begin
            w_state_nxt = S_RET;
          end else begin
            w_state_nxt = S_RET_D;
            if (w_decoy_live) w_trip_nxt = r_trip + 1'b1;
          end
        end
        S_RET: begin
          w_job_nxt   = r_job_cnt + 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_RET_D: begin
          if (w_decoy_live) w_job_nxt = r_job_cnt + 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_FAULT: begin
          w_state_nxt = S_FAULT;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    motor_en    = '0;
    grip        = 1'b0;
    release_out = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);
    fault       = 1'b0;
    case (r_state)
      S_MOVE:  motor_en = N_AXIS'(1) << r_ax;
      S_GRIP:  grip = 1'b1;
      S_CHECK: grip = 1'b1;
      S_RET: begin
        release_out = 1'b1;
        done        = 1'b1;
      end
      S_RET_D: begin
        release_out = w_decoy_live;
        done        = w_decoy_live;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign job_cnt   = r_job_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_locked_axis_sequencer.sv
// Bench for locked_axis_sequencer: directed scenarios plus randomized traffic,
// every cycle compared against a job-level reference model.
module tb_locked_axis_sequencer;

  localparam int               N_AXIS  = 3;
  localparam int               KEY_W   = 4;
  localparam logic [KEY_W-1:0] KEY_VAL = 4'hA;
  localparam int               CA      = 5;
  localparam int               TIMEOUT = 16;
  localparam int               CNT_W   = 8;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [N_AXIS-1:0] sense = '0;
  logic              grip_ok = 1'b0;
  logic [KEY_W-1:0]  keyinput = '0;
  logic [N_AXIS-1:0] motor_en;
  logic              grip;
  logic              release_out;
  logic              done;
  logic              busy;
  logic              fault;
  logic [CNT_W-1:0]  job_cnt;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  locked_axis_sequencer #(
    .N_AXIS(N_AXIS), .KEY_W(KEY_W), .KEY_VAL(KEY_VAL),
    .CORRUPT_AFTER(CA), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sense(sense),
    .grip_ok(grip_ok), .keyinput(keyinput), .motor_en(motor_en),
    .grip(grip), .release_out(release_out), .done(done), .busy(busy),
    .fault(fault), .job_cnt(job_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_MOVE, P_GRIP, P_CHECK, P_RET, P_RET_D, P_FAULT} phase_t;
  phase_t m_phase;
  int     m_ax;
  int     m_wait;    // cycles spent waiting at the current step
  int     m_decoys;  // wrong-key entries since reset (unbounded)
  int     m_jobs;

  task automatic model_reset();
    m_phase = P_IDLE; m_ax = 0; m_wait = 0; m_decoys = 0; m_jobs = 0;
  endtask

  function automatic bit decoy_ok();
    return m_decoys < CA;
  endfunction

  task automatic model_step();
    phase_t p;
    p = m_phase;
    if (abort && p != P_IDLE) begin
      m_phase = P_IDLE;
      m_wait  = 0;
      return;
    end
    case (p)
      P_IDLE: if (start) begin m_phase = P_MOVE; m_ax = 0; m_wait = 0; end
      P_MOVE: begin
        if (sense[m_ax]) begin
          m_wait = 0;
          if (m_ax == N_AXIS - 1) m_phase = P_GRIP;
          else m_ax = m_ax + 1;
        end else if (m_wait == TIMEOUT - 1) begin
          m_phase = P_FAULT; m_wait = 0;
        end else m_wait++;
      end
      P_GRIP: begin
        if (grip_ok) begin m_phase = P_CHECK; m_wait = 0; end
        else if (m_wait == TIMEOUT - 1) begin m_phase = P_FAULT; m_wait = 0; end
        else m_wait++;
      end
      P_CHECK: begin
        if (keyinput == KEY_VAL) m_phase = P_RET;
        else begin m_decoys++; m_phase = P_RET_D; end
      end
      P_RET: begin m_jobs = (m_jobs + 1) % (1 << CNT_W); m_phase = P_IDLE; end
      P_RET_D: begin
        if (decoy_ok()) m_jobs = (m_jobs + 1) % (1 << CNT_W);
        m_phase = P_IDLE;
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    logic [N_AXIS-1:0] e_motor;
    logic              e_ret;
    e_motor = '0;
    if (m_phase == P_MOVE) e_motor[m_ax] = 1'b1;
    e_ret = (m_phase == P_RET) || (m_phase == P_RET_D && decoy_ok());
    check("motor_en", motor_en, e_motor);
    check("grip", grip, (m_phase == P_GRIP || m_phase == P_CHECK));
    check("release", release_out, e_ret);
    check("done", done, e_ret);
    check("busy", busy, (m_phase != P_IDLE));
    check("fault", fault, (m_phase == P_FAULT));
    check("job_cnt", job_cnt, m_jobs);
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after the rising edge; the DUT acts on the falling edge.
  task automatic step_cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    check_outputs();
    if (done) n_done++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_motor_en", motor_en, 0);
    check("rst_grip", grip, 0);
    check("rst_release", release_out, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_job_cnt", job_cnt, 0);
    check("rst_state", dbg_state, 0);
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic one_job();
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    run(6);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(posedge clk);
    do_reset();

    // Correct key, all sensors high: timeline from the start edge.
    keyinput = KEY_VAL; sense = '1; grip_ok = 1'b1; start = 1'b1;
    step_cycle(); check("t1_mot0", motor_en, 3'b001); start = 1'b0;
    step_cycle(); check("t1_mot1", motor_en, 3'b010);
    step_cycle(); check("t1_mot2", motor_en, 3'b100);
    step_cycle(); check("t1_grip0", grip, 1);
    step_cycle(); check("t1_grip1", grip, 1); check("t1_nodone", done, 0);
    step_cycle(); check("t1_done", done, 1); check("t1_rel", release_out, 1);
    step_cycle(); check("t1_done_off", done, 0); check("t1_idle", busy, 0);
    check("t1_jobs", job_cnt, 1);

    // Wrong key, six jobs: four convincing, then silent.
    do_reset();
    keyinput = 4'h3;
    for (int j = 0; j < 6; j++) begin
      n_done = 0;
      one_job();
      check("t2_busy", busy, 0);
      check("t2_pulses", n_done, (j < 4) ? 1 : 0);
    end
    check("t2_jobs", job_cnt, 4);

    // Axis 1 never in position: watchdog fault, then abort.
    do_reset();
    keyinput = KEY_VAL; sense = 3'b001; grip_ok = 1'b0; start = 1'b1;
    step_cycle(); start = 1'b0;
    step_cycle(); check("t3_ax1", motor_en, 3'b010);
    run(15); check("t3_prefault", fault, 0);
    step_cycle(); check("t3_fault", fault, 1); check("t3_mot_off", motor_en, 0);
    check("t3_busy", busy, 1);
    abort = 1'b1; step_cycle(); abort = 1'b0;
    check("t3_unfault", fault, 0); check("t3_idle", busy, 0);

    // Sensor arrives on the expiry cycle: advance wins over timeout.
    do_reset();
    sense = '0; grip_ok = 1'b1; start = 1'b1;
    step_cycle(); start = 1'b0;
    run(15);
    sense = 3'b001;
    step_cycle(); check("t4_adv", motor_en, 3'b010); check("t4_nofault", fault, 0);
    sense = '1;
    run(6); check("t4_idle", busy, 0); check("t4_jobs", job_cnt, 1);

    // Wrong key five times, reset in GRIP, then the decoy works again.
    do_reset();
    keyinput = 4'h3; sense = '1; grip_ok = 1'b1;
    for (int j = 0; j < 5; j++) one_job();
    check("t5_jobs", job_cnt, 4);
    grip_ok = 1'b0; start = 1'b1;
    step_cycle(); start = 1'b0;
    run(3); check("t5_in_grip", grip, 1);
    do_reset();
    grip_ok = 1'b1; n_done = 0;
    one_job();
    check("t5_decoy_ok", n_done, 1); check("t5_jobs_after", job_cnt, 1);

    // Job counter wrap.
    do_reset();
    keyinput = KEY_VAL; sense = '1; grip_ok = 1'b1;
    for (int j = 0; j < 256; j++) begin
      one_job();
      if (j == 254) check("t6_cnt255", job_cnt, 255);
    end
    check("t6_wrap", job_cnt, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      start   = ($urandom_range(0, 9) < 3);
      abort   = ($urandom_range(0, 39) == 0);
      grip_ok = $urandom_range(0, 1);
      for (int b = 0; b < N_AXIS; b++) sense[b] = ($urandom_range(0, 9) < 6);
      keyinput = $urandom_range(0, 1) ? KEY_VAL : KEY_W'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_reset();
      step_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
